noc_rx_fifo: RTL and testbench

Receive-side buffer between the NoC port and the 32-bit input PIO read by the Nios processor. Accepts words from the NoC with a valid/ready handshake and stores them in a small FIFO. Presents the head word, show-ahead, on `data_out`, which is wired to the PIO `in_port`. Software releases the head word by flipping a toggle bit driven from an output PIO, so no Avalon strobe reaches this block.

---
 rtl/noc_rx_fifo.sv | 48 ++++
 tb/tb_noc_rx_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/noc_rx_fifo.sv
// noc_rx_fifo: show-ahead NoC receive FIFO (noc_data/valid/ready in; data_out/data_valid/fill_level/underflow out; ack_toggle level change pops the head)
module noc_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       noc_data,
  input  logic              noc_valid,
  output logic              noc_ready,
  output logic [31:0]       data_out,
  output logic              data_valid,
  input  logic              ack_toggle,
  output logic [ADDR_W:0]   fill_level,
  output logic              underflow
);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ack_q, full, empty, push, pop, ack_evt;
  always_comb begin
    full       = count == FULL_CNT;
    empty      = count == '0;
    ack_evt    = ack_toggle ^ ack_q;
    push       = noc_valid && !full;
    pop        = ack_evt && !empty;
    noc_ready  = !full;
    data_valid = !empty;
    data_out   = empty ? '0 : mem[rd_ptr];
    fill_level = count;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= noc_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ack_q     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ack_q     <= ack_toggle;
      wr_ptr    <= wr_ptr + ADDR_W'(push);
      rd_ptr    <= rd_ptr + ADDR_W'(pop);
      count     <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      underflow <= underflow || (ack_evt && empty);
    end
endmodule

// File: tb/tb_noc_rx_fifo.sv
// tb_noc_rx_fifo: directed self-checking bench for noc_rx_fifo
module tb_noc_rx_fifo;
  logic        clk = 0, reset_n = 0, noc_valid = 0, ack_toggle = 0;
  logic [31:0] noc_data = 0;
  logic        noc_ready, data_valid, underflow;
  logic [31:0] data_out;
  logic [2:0]  fill_level;
  int errors = 0, checks = 0;
  noc_rx_fifo #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .noc_data(noc_data), .noc_valid(noc_valid),
    .noc_ready(noc_ready), .data_out(data_out), .data_valid(data_valid),
    .ack_toggle(ack_toggle), .fill_level(fill_level), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic flip();
    ack_toggle = ~ack_toggle;
  endtask
  initial begin
    step();
    step();
    chk("rst_dout", data_out, 0);
    chk("rst_valid", {31'b0, data_valid}, 0);
    chk("rst_fill", {29'b0, fill_level}, 0);
    chk("rst_ready", {31'b0, noc_ready}, 1);
    chk("rst_uf", {31'b0, underflow}, 0);
    reset_n = 1;
    step();
    noc_data = 32'hDEADBEEF; noc_valid = 1;
    step();
    noc_valid = 0;
    chk("t1_valid", {31'b0, data_valid}, 1);
    chk("t1_dout", data_out, 32'hDEADBEEF);
    chk("t1_fill", {29'b0, fill_level}, 1);
    flip();
    step();
    chk("t1_pop_dout", data_out, 0);
    chk("t1_pop_valid", {31'b0, data_valid}, 0);
    noc_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      noc_data = i;
      step();
    end
    chk("t2_ready", {31'b0, noc_ready}, 0);
    chk("t2_fill", {29'b0, fill_level}, 4);
    noc_data = 5;
    step();
    chk("t2_fill_hold", {29'b0, fill_level}, 4);
    chk("t2_head", data_out, 1);
    flip();
    step();
    chk("t2_pop_head", data_out, 2);
    chk("t2_pop_ready", {31'b0, noc_ready}, 1);
    chk("t2_pop_fill", {29'b0, fill_level}, 3);
    step();
    noc_valid = 0;
    chk("t2_refill", {29'b0, fill_level}, 4);
    for (int i = 3; i <= 5; i++) begin
      flip();
      step();
      chk("t2_drain", data_out, i);
    end
    flip();
    step();
    chk("t2_empty", {31'b0, data_valid}, 0);
    step();
    chk("t2_hold_fill", {29'b0, fill_level}, 0);
    chk("t2_hold_uf", {31'b0, underflow}, 0);
    noc_valid = 1;
    noc_data = 32'hA; step();
    noc_data = 32'hB; step();
    chk("t3_pre_fill", {29'b0, fill_level}, 2);
    chk("t3_pre_head", data_out, 32'hA);
    noc_data = 32'hC; flip();
    step();
    noc_valid = 0;
    chk("t3_fill", {29'b0, fill_level}, 2);
    chk("t3_head", data_out, 32'hB);
    flip(); step();
    chk("t3_next", data_out, 32'hC);
    flip(); step();
    chk("t3_empty", {31'b0, data_valid}, 0);
    noc_valid = 1; noc_data = 32'h100;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t4_order", data_out, 32'h100 + i);
      chk("t4_fill", {29'b0, fill_level}, 1);
      noc_valid = i < 9;
      noc_data = 32'h101 + i;
      flip();
      step();
    end
    noc_valid = 0;
    chk("t4_empty", {31'b0, data_valid}, 0);
    flip();
    step();
    chk("t5_uf", {31'b0, underflow}, 1);
    chk("t5_fill", {29'b0, fill_level}, 0);
    noc_valid = 1; noc_data = 32'h77;
    step();
    noc_valid = 0;
    chk("t5_uf_sticky", {31'b0, underflow}, 1);
    chk("t5_dout", data_out, 32'h77);
    flip(); step();
    chk("t5_uf_sticky2", {31'b0, underflow}, 1);
    reset_n = 0; ack_toggle = 0;
    #1;
    chk("t5_uf_clr", {31'b0, underflow}, 0);
    step();
    reset_n = 1;
    step();
    noc_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      noc_data = 32'h50 + i;
      step();
    end
    noc_valid = 0;
    chk("t6_fill3", {29'b0, fill_level}, 3);
    #3;
    noc_valid = 1; noc_data = 32'h99; reset_n = 0;
    #1;
    chk("t6_valid", {31'b0, data_valid}, 0);
    chk("t6_fill", {29'b0, fill_level}, 0);
    chk("t6_dout", data_out, 0);
    chk("t6_ready", {31'b0, noc_ready}, 1);
    step();
    noc_valid = 0;
    reset_n = 1;
    step();
    chk("t6_lost", {29'b0, fill_level}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
